sll_iter: RTL and testbench
===========================

# sll_iter

Iterative 32-bit logical left shifter for the ALU. It is the left-shift counterpart of the combinational arithmetic right shifter. It applies one power-of-two shift stage per clock, giving a short critical path, and uses a start/ready handshake. It sits beside the ALU datapath as a multi-cycle functional unit, launched the same way as the multiply/divide units.

## Interface
- `WIDTH`, 32: operand/result width. Only 32 is supported; the shift-amount width is fixed at 5.
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high. All state and outputs are cleared on the clock edge where it is sampled high.
- `ctrl_shift`  in  1: start strobe. Sampled only in IDLE or DONE.
- `data_operandA`  in  32: value to shift. Captured with `ctrl_shift`.
- `ctrl_shiftamt`  in  5: shift amount 0–31. Captured with `ctrl_shift`.
- `data_result`  out  32: shifted value. Registered; holds until the next operation completes.
- `data_resultRDY`  out  1: one-cycle pulse; `data_result` is valid while it is high.
- `busy`  out  1: high in SHIFT state.
- `data_exception`  out  1: overflow flag, valid with `data_resultRDY` (see Configuration).

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE:
  - On `ctrl_shift`=1, latch operand into the working register and amount into the amount register.
  - Clear stage counter `cnt` (3 bits) and the sticky overflow bit; go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT: each edge performs stage `cnt` (0..4).
  - If `amt[cnt]`=1: working register <= working << (1<<cnt), zero-filled from the LSB.
  - Also in that case, the sticky overflow ORs in any nonzero bit among the top (1<<cnt) bits shifted out.
  - If `amt[cnt]`=0: register unchanged.
  - `cnt` increments. On the edge executing `cnt`=4, go to DONE and load `data_result` and `data_exception` from the working and sticky registers.
- DONE: `data_resultRDY`=1 for this single cycle.
  - If `ctrl_shift`=1, start a new operation exactly as in IDLE, going straight to SHIFT (back-to-back).
  - Otherwise go to IDLE.
- `ctrl_shift` during SHIFT is ignored and not queued; inputs may change freely once captured.
- Stages run for all five bits regardless of amount (no early exit), so latency is fixed.
- Result equals `data_operandA << ctrl_shiftamt` truncated to 32 bits. Amount 0 passes the operand through unchanged.

## Timing
- Start sampled at edge E0. Stages 0..4 execute at E1..E5, and `busy`=1 during the cycles between E0 and E5.
- `data_resultRDY` is high for the cycle after E5: latency 5 clocks from the sampling edge.
- Back-to-back throughput: one operation per 6 clocks. A start sampled in DONE at E6 gives the next ready after E11.
- Reset values: `data_result`=0, `data_resultRDY`=0, `busy`=0, `data_exception`=0; FSM IDLE, `cnt`=0.
- Reset mid-SHIFT aborts the operation:
  - No `data_resultRDY` pulse is produced for it.
  - `data_result` is cleared to 0.
  - A `ctrl_shift` on the reset edge is ignored.
- Reset has priority over `ctrl_shift` in every state.

## Configuration
- `SLL_OVF_EN` defined: sticky overflow logic is present, and `data_exception` reports whether any 1 bit was shifted out past bit 31.
- `SLL_OVF_EN` undefined: overflow logic is removed and `data_exception` is tied to 0. All other behaviour and timing are identical.

## Test plan
- Basic shift: A=0x0000_0001, amt=31, start at E0.
  - Required: `busy`=1 from E0 to E5; `data_resultRDY` pulses only in the cycle after E5.
  - Required: `data_result`=0x8000_0000, `data_exception`=0.
- Overflow: A=0xFFFF_FFFF, amt=4.
  - Required: result 0xFFFF_FFF0.
  - Required: `data_exception`=1 with `SLL_OVF_EN`, 0 without.
- Zero amount: A=0x1234_5678, amt=0.
  - Required: result 0x1234_5678 after the same 5-clock latency; `data_exception`=0.
- Handshake boundaries: start A=0x0000_00FF, amt=8.
  - Assert `ctrl_shift` again with A=0xFFFF_FFFF at E2 (during SHIFT): it is ignored; result 0x0000_FF00.
  - Then assert `ctrl_shift` in DONE with A=0x3, amt=1: it is accepted back-to-back; next ready 6 clocks later with 0x6.
- Reset mid-operation: start A=0xAAAA_AAAA, amt=1; assert `reset` at E3.
  - Required: all outputs 0 from E3 and no ready pulse.
  - A fresh start after reset deasserts behaves normally.

Source files
------------

// File: rtl/sll_iter.sv
// Iterative 32-bit logical left shifter: one power-of-two stage per clock, start/ready handshake.
// Define SLL_OVF_EN to include sticky overflow detection on data_exception.
module sll_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_shift,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [4:0]       ctrl_shiftamt,
  output logic [WIDTH-1:0] data_result,
  output logic             data_resultRDY,
  output logic             busy,
  output logic             data_exception
);

  localparam int unsigned AMT_W = 5;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned SH_W  = 6;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic             exc_q, exc_d;
  logic [SH_W-1:0]  stage_sh;
  logic [WIDTH-1:0] stage_val;
`ifdef SLL_OVF_EN
  logic             ovf_q, ovf_d;
  logic             stage_lost;
`endif

  // Current stage: shift by 2^cnt; bits pushed past the MSB feed the sticky flag.
  always_comb begin
    stage_sh  = SH_W'(1) << cnt_q;
    stage_val = work_q << stage_sh;
`ifdef SLL_OVF_EN
    stage_lost = |(work_q >> (SH_W'(WIDTH) - stage_sh));
`endif
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    amt_d    = amt_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    exc_d    = exc_q;
`ifdef SLL_OVF_EN
    ovf_d    = ovf_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (ctrl_shift) begin
          state_d = SHIFT;
          work_d  = data_operandA;
          amt_d   = ctrl_shiftamt;
          cnt_d   = '0;
`ifdef SLL_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      SHIFT: begin
        if (amt_q[cnt_q]) begin
          work_d = stage_val;
`ifdef SLL_OVF_EN
          ovf_d  = ovf_q | stage_lost;
`endif
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(4)) begin
          state_d  = DONE;
          result_d = work_d;
`ifdef SLL_OVF_EN
          exc_d    = ovf_d;
`else
          exc_d    = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    rdy_d  = (state_d == DONE);
    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      work_q   <= '0;
      amt_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
      exc_q    <= 1'b0;
`ifdef SLL_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      amt_q    <= amt_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
      exc_q    <= exc_d;
`ifdef SLL_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign data_result    = result_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;
  assign data_exception = exc_q;

endmodule

// File: tb/tb_sll_iter.sv
// Randomized self-checking bench for sll_iter against a plain-arithmetic shift model.
module tb_sll_iter;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_shift;
  logic [31:0] data_operandA;
  logic [4:0]  ctrl_shiftamt;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        busy;
  logic        data_exception;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] last_result;

  always #5 clock = ~clock;

  sll_iter #(.WIDTH(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .ctrl_shift    (ctrl_shift),
    .data_operandA (data_operandA),
    .ctrl_shiftamt (ctrl_shiftamt),
    .data_result   (data_result),
    .data_resultRDY(data_resultRDY),
    .busy          (busy),
    .data_exception(data_exception)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Reference: the full-precision product of a * 2^amt, split into kept and lost halves.
  task automatic model(input logic [31:0] a, input logic [4:0] amt,
                       output logic [31:0] res, output logic exc);
    logic [63:0] wide;
    wide = {32'd0, a} << amt;
    res  = wide[31:0];
`ifdef SLL_OVF_EN
    exc  = |wide[63:32];
`else
    exc  = 1'b0;
`endif
  endtask

  // Called at a negedge; returns at the negedge inside the DONE (ready) cycle.
  // poke_k in 0..3 re-asserts ctrl_shift with garbage during SHIFT; -1 disables.
  task automatic run_op(input logic [31:0] a, input logic [4:0] amt, input int poke_k,
                        input string tag);
    logic [31:0] er;
    logic        ee;
    model(a, amt, er, ee);
    ctrl_shift    = 1'b1;
    data_operandA = a;
    ctrl_shiftamt = amt;
    @(posedge clock);
    @(negedge clock);
    for (int k = 0; k < 5; k++) begin
      check({tag, ".busy"}, 32'(busy), 32'd1);
      check({tag, ".rdy_low"}, 32'(data_resultRDY), 32'd0);
      ctrl_shift    = (k == poke_k);
      data_operandA = (k == poke_k) ? 32'hFFFF_FFFF : $urandom;
      ctrl_shiftamt = 5'($urandom);
      @(negedge clock);
    end
    ctrl_shift = 1'b0;
    check({tag, ".busy_done"}, 32'(busy), 32'd0);
    check({tag, ".rdy"}, 32'(data_resultRDY), 32'd1);
    check({tag, ".result"}, data_result, er);
    check({tag, ".exc"}, 32'(data_exception), 32'(ee));
    last_result = er;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    ctrl_shift = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      check({tag, ".idle_rdy"}, 32'(data_resultRDY), 32'd0);
      check({tag, ".idle_busy"}, 32'(busy), 32'd0);
      check({tag, ".hold"}, data_result, last_result);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [4:0]  amt;
    reset         = 1'b1;
    ctrl_shift    = 1'b0;
    data_operandA = '0;
    ctrl_shiftamt = '0;
    last_result   = '0;
    repeat (2) @(negedge clock);
    check("reset.result", data_result, 32'd0);
    check("reset.rdy", 32'(data_resultRDY), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.exc", 32'(data_exception), 32'd0);
    reset = 1'b0;
    idle_cycles(2, "post_reset");

    run_op(32'h0000_0001, 5'd31, -1, "basic");
    idle_cycles(2, "basic");
    run_op(32'hFFFF_FFFF, 5'd4, -1, "ovf");
    idle_cycles(1, "ovf");
    run_op(32'h1234_5678, 5'd0, -1, "zero_amt");
    idle_cycles(1, "zero_amt");

    // Start ignored during SHIFT, then back-to-back start accepted in DONE.
    run_op(32'h0000_00FF, 5'd8, 1, "ignore_mid");
    run_op(32'h0000_0003, 5'd1, -1, "back2back");
    idle_cycles(1, "back2back");

    // Reset at E3 aborts; a start presented on the reset edge is dropped.
    ctrl_shift    = 1'b1;
    data_operandA = 32'hAAAA_AAAA;
    ctrl_shiftamt = 5'd1;
    @(posedge clock);
    @(negedge clock);
    ctrl_shift = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset         = 1'b1;
    ctrl_shift    = 1'b1;
    data_operandA = 32'h0000_0001;
    @(negedge clock);
    check("midrst.result", data_result, 32'd0);
    check("midrst.rdy", 32'(data_resultRDY), 32'd0);
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.exc", 32'(data_exception), 32'd0);
    reset       = 1'b0;
    last_result = '0;
    idle_cycles(7, "midrst");
    run_op(32'h0000_0005, 5'd3, -1, "after_rst");

    // Randomized operations with random gaps, pokes and back-to-back starts.
    for (int i = 0; i < 40; i++) begin
      a   = $urandom;
      amt = 5'($urandom_range(0, 31));
      if (i % 5 == 0) a = 32'h8000_0000 >> $urandom_range(0, 31);
      run_op(a, amt, $urandom_range(0, 4) - 1, "rand");
      if ($urandom_range(0, 2) != 0) idle_cycles($urandom_range(1, 3), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
